// File: rtl/fp_align_add_pkg.sv
// rtl/fp_align_add_pkg.sv - binary32 field layout, widths and unpack helpers for the align/add stage
package fp_align_add_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXT_W    = 4;
    localparam int MS_W     = 1 + FRAC_W + EXT_W;
    localparam int SH_W     = 5;
    localparam int BIAS     = 127;
    localparam int WORD_W   = 1 + EXP_W + FRAC_W;
    localparam int SIGN_POS = WORD_W - 1;
    localparam int EXP_LSB  = FRAC_W;
    localparam int EXP_MSB  = FRAC_W + EXP_W - 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Hidden bit is set only for non-zero exponent fields; extension bits start clear.
    function automatic logic [MS_W-1:0] unpack_sig(fp32_t f);
        return {(f.exp != '0), f.frac, {EXT_W{1'b0}}};
    endfunction

    // Zero and denormal operands share the scale of the smallest normal exponent.
    function automatic logic [EXP_W-1:0] eff_exp(fp32_t f);
        return (f.exp == '0) ? EXP_W'(1) : f.exp;
    endfunction

endpackage

// File: rtl/fp_align_add_if.sv
// rtl/fp_align_add_if.sv - operand input and aligned-sum output handshakes of the align/add stage
interface fp_align_add_if;
    import fp_align_add_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [MS_W-1:0]   MS;
    logic [EXP_W-1:0]  ES;
    logic              Co;
    logic              sign;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, MS, ES, Co, sign
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, MS, ES, Co, sign
    );

endinterface

// File: rtl/fp_align_add_shift_right_sticky.sv
// rtl/fp_align_add_shift_right_sticky.sv - right shifter that ORs every shifted-out bit into bit 0
module fp_align_add_shift_right_sticky #(
    parameter int W     = 28,
    parameter int AMT_W = 5
) (
    input  logic [W-1:0]     din,
    input  logic [AMT_W-1:0] amt,
    input  logic             sat,
    output logic [W-1:0]     dout
);

    logic         lost;
    logic [W-1:0] shifted;

    // Shift, collect the dropped bits as sticky; saturation collapses to a lone sticky bit.
    always_comb begin
        lost    = |(din & ~({W{1'b1}} << amt));
        shifted = din >> amt;
        if (sat) begin
            dout = {{(W-1){1'b0}}, |din};
        end else begin
            dout = {shifted[W-1:1], shifted[0] | lost};
        end
    end

endmodule

// File: rtl/fp_align_add.sv
// rtl/fp_align_add.sv - two-stage magnitude order, sticky align and add/sub ahead of normalisation
module fp_align_add
    import fp_align_add_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fp_align_add_if.slave bus
);

    fp32_t            op_a;
    fp32_t            op_b_eff;
    fp32_t            big;
    logic             a_is_large;
    logic [MS_W-1:0]  sig_big;
    logic [MS_W-1:0]  sig_small;
    logic [MS_W-1:0]  sig_small_aligned;
    logic [EXP_W-1:0] exp_diff;
    logic             diff_sat;
    logic             eff_sub;

    logic             s1_en;
    logic             s2_en;
    logic             s1_valid;
    logic [MS_W-1:0]  s1_sig_a;
    logic [MS_W-1:0]  s1_sig_b;
    logic [EXP_W-1:0] s1_exp;
    logic             s1_sign;
    logic             s1_eff_sub;

    logic [MS_W:0]    sum;
    logic [MS_W-1:0]  diff;
    logic [MS_W-1:0]  ms_next;
    logic             co_next;
    logic             sign_next;

    logic             out_valid_q;
    logic [MS_W-1:0]  ms_q;
    logic [EXP_W-1:0] es_q;
    logic             co_q;
    logic             sign_q;

    // Ready ripples back from the normaliser so a full pipe still moves one item per cycle.
    assign s2_en        = !out_valid_q || bus.out_ready;
    assign s1_en        = !s1_valid || s2_en;
    assign bus.in_ready = s1_en;

    // The subtract request is folded into b's sign so ordering only ever sees an addition.
    always_comb begin
        op_a          = bus.a;
        op_b_eff      = bus.b;
        op_b_eff.sign = bus.b[SIGN_POS] ^ bus.sub;
    end

    // Magnitude order on {exp,frac}; a tie keeps operand a on top.
    assign a_is_large = {op_a.exp, op_a.frac} >= {op_b_eff.exp, op_b_eff.frac};
    assign big        = a_is_large ? op_a : op_b_eff;
    assign sig_big    = unpack_sig(big);
    assign sig_small  = unpack_sig(a_is_large ? op_b_eff : op_a);
    assign exp_diff   = eff_exp(big) - eff_exp(a_is_large ? op_b_eff : op_a);
    assign diff_sat   = exp_diff >= EXP_W'(MS_W);
    assign eff_sub    = op_a.sign ^ op_b_eff.sign;

    fp_align_add_shift_right_sticky #(
        .W     (MS_W),
        .AMT_W (SH_W)
    ) u_align (
        .din  (sig_small),
        .amt  (exp_diff[SH_W-1:0]),
        .sat  (diff_sat),
        .dout (sig_small_aligned)
    );

    // Stage 1 captures the ordered, aligned operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sig_a   <= '0;
            s1_sig_b   <= '0;
            s1_exp     <= '0;
            s1_sign    <= 1'b0;
            s1_eff_sub <= 1'b0;
        end else if (s1_en) begin
            s1_valid   <= bus.in_valid;
            s1_sig_a   <= sig_big;
            s1_sig_b   <= sig_small_aligned;
            s1_exp     <= big.exp;
            s1_sign    <= big.sign;
            s1_eff_sub <= eff_sub;
        end
    end

    assign sum  = {1'b0, s1_sig_a} + {1'b0, s1_sig_b};
    assign diff = s1_sig_a - s1_sig_b;

    // Carry-out pre-shifts the sum keeping sticky; an exact cancellation yields +0.
    always_comb begin
        ms_next   = sum[MS_W-1:0];
        co_next   = 1'b0;
        sign_next = s1_sign;
        if (s1_eff_sub) begin
            ms_next = diff;
            if (diff == '0) begin
                sign_next = 1'b0;
            end
        end else if (sum[MS_W]) begin
            ms_next = {sum[MS_W], sum[MS_W-1:2], sum[1] | sum[0]};
            co_next = 1'b1;
        end
    end

    // Stage 2 holds the result for the normaliser until it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ms_q        <= '0;
            es_q        <= '0;
            co_q        <= 1'b0;
            sign_q      <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid;
            ms_q        <= ms_next;
            es_q        <= s1_exp;
            co_q        <= co_next;
            sign_q      <= sign_next;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.MS        = ms_q;
    assign bus.ES        = es_q;
    assign bus.Co        = co_q;
    assign bus.sign      = sign_q;

endmodule

// File: tb/tb_fp_align_add.sv
// tb/tb_fp_align_add.sv - directed vectors scored against a behavioural align/add model
module tb_fp_align_add;
    import fp_align_add_pkg::*;

    typedef struct {
        logic [27:0] ms;
        logic [7:0]  es;
        logic        co;
        logic        sign;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fp_align_add_if bus ();

    fp_align_add dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    res_t exp_q[$];
    res_t cur;
    res_t pin;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   out_cnt   = 0;
    int   cnt0;

    logic [31:0] va [12] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h40000000, 32'h3F800000, 32'h7F800000, 32'h00400000,
                             32'hC0000000, 32'h00000000, 32'h3FFFFFFF, 32'hBF800000};
    logic [31:0] vb [12] = '{32'h3F800000, 32'h3F800000, 32'h2B800000, 32'hBFC00000,
                             32'h3F800000, 32'h33800000, 32'h3F800000, 32'h00000001,
                             32'hC0000000, 32'h80000000, 32'h3F800001, 32'h3F800000};
    logic        vs [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, want %h at %0t", nm, act, req, $time);
    endtask

    // Exact-value model: integer significands, divide for alignment, remainder for sticky.
    function automatic res_t model(logic [31:0] a, logic [31:0] b, logic s);
        res_t        r;
        logic [31:0] bb, big, sml;
        longint      ea, eb, siga, sigb, d, p, rem, sum;
        bb = {b[31] ^ s, b[30:0]};
        if (b[30:0] > a[30:0]) begin
            big = bb; sml = a;
        end else begin
            big = a;  sml = bb;
        end
        ea   = longint'(big[30:23]);
        eb   = longint'(sml[30:23]);
        siga = ((ea != 0) ? longint'(2**23) : 0) + longint'(big[22:0]);
        sigb = ((eb != 0) ? longint'(2**23) : 0) + longint'(sml[22:0]);
        siga = siga * 16;
        sigb = sigb * 16;
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        d = ea - eb;
        if (d >= 28) begin
            sigb = (sigb != 0) ? 1 : 0;
        end else begin
            p    = longint'(64'd1 << d);
            rem  = sigb % p;
            sigb = sigb / p;
            if (rem != 0) sigb = sigb | 1;
        end
        r.es = big[30:23];
        if ((a[31] ^ bb[31]) == 1'b0) begin
            sum    = siga + sigb;
            r.sign = big[31];
            if (sum >= longint'(2**28)) begin
                r.co = 1'b1;
                r.ms = 28'((sum / 2) | (sum % 2));
            end else begin
                r.co = 1'b0;
                r.ms = 28'(sum);
            end
        end else begin
            sum    = siga - sigb;
            r.co   = 1'b0;
            r.ms   = 28'(sum);
            r.sign = (sum == 0) ? 1'b0 : big[31];
        end
        return r;
    endfunction

    // Every cycle with a result on the output it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                cur = exp_q[0];
                chk("MS",   bus.MS,   cur.ms);
                chk("ES",   bus.ES,   cur.es);
                chk("Co",   bus.Co,   cur.co);
                chk("sign", bus.sign, cur.sign);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    out_cnt++;
                end
            end
        end
    end

    task automatic send(logic [31:0] a, logic [31:0] b, logic s);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(model(a, b, s));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain_left", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Hand-computed pins for the model itself.
        pin = model(32'h3F800000, 32'h3F800000, 1'b0);
        chk("pin1_ms", pin.ms, 28'h8000000);
        chk("pin1_es", pin.es, 8'h7F);
        chk("pin1_co", pin.co, 1'b1);
        chk("pin1_sign", pin.sign, 1'b0);
        pin = model(32'h3F800000, 32'h3F800000, 1'b1);
        chk("pin2_ms", pin.ms, 28'h0000000);
        chk("pin2_co", pin.co, 1'b0);
        pin = model(32'h3F800000, 32'h2B800000, 1'b0);
        chk("pin3_ms", pin.ms, 28'h8000001);
        chk("pin3_co", pin.co, 1'b0);
        pin = model(32'h3F800000, 32'hBFC00000, 1'b0);
        chk("pin4_ms", pin.ms, 28'h4000000);
        chk("pin4_sign", pin.sign, 1'b1);
        pin = model(32'h40000000, 32'h3F800000, 1'b0);
        chk("pin5_ms", pin.ms, 28'hC000000);
        chk("pin5_es", pin.es, 8'h80);
        pin = model(32'h3F800000, 32'h33800000, 1'b1);
        chk("pin6_ms", pin.ms, 28'h7FFFFF8);

        // Reset state.
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 32'd0);
        chk("rst_MS", bus.MS, 32'd0);
        chk("rst_ES", bus.ES, 32'd0);
        chk("rst_Co", bus.Co, 32'd0);
        chk("rst_sign", bus.sign, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 32'd1);

        // Directed stream, back to back, normaliser always ready.
        foreach (va[i]) send(va[i], vb[i], vs[i]);
        drain();
        chk("stream_count", out_cnt, 32'd12);

        // Back-pressure: two accepts fill the pipe, third waits.
        bus.out_ready = 1'b0;
        cnt0 = out_cnt;
        send(32'h3F800000, 32'h40400000, 1'b0);
        send(32'h41200000, 32'h3F000000, 1'b1);
        bus.in_valid = 1'b1;
        bus.a        = 32'hC1200000;
        bus.b        = 32'h41200000;
        bus.sub      = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 32'd0);
            chk("stall_out_valid", bus.out_valid, 32'd1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(32'hC1200000, 32'h41200000, 1'b0);
        drain();
        chk("bp_count", out_cnt - cnt0, 32'd3);

        // Reset with a full pipe discards everything in flight.
        bus.out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0);
        send(32'h40000000, 32'h40000000, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 32'd0);
        chk("midrst_MS", bus.MS, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("midrst_in_ready", bus.in_ready, 32'd1);
        cnt0 = out_cnt;
        send(32'h3F800000, 32'hBFC00000, 1'b0);
        drain();
        chk("post_rst_count", out_cnt - cnt0, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
